base_sfifo: RTL and testbench

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly upstream of the team's enabled data-capture registers and buffers bursts from a producer. The consumer's accept condition (o_v & o_r) drives the downstream register enable, and o_d drives its data input. Bit ordering is [0:width-1], with bit 0 as the MSB, matching the downstream register.

---
 rtl/base_sfifo.sv | 77 +++++++
 tb/tb_base_sfifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/base_sfifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
// Occupancy counter is the single source of full/empty; o_d reads storage at rptr.
module base_sfifo #(
  parameter int width  = 1,
  parameter int depth  = 4,
  parameter int awidth = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_v,
  output logic              i_r,
  input  logic [0:width-1]  i_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [0:width-1]  o_d,
  output logic [0:awidth]   cnt,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam logic [awidth:0]   DEPTH_C = (awidth+1)'(depth);
  localparam logic [awidth:0]   CNT_ONE = (awidth+1)'(1);
  localparam logic [awidth-1:0] PTR_ONE = awidth'(1);

  logic [0:width-1]  mem [0:depth-1];
  logic [awidth-1:0] rptr, wptr;
  logic [awidth:0]   count;
  logic              stall_q;
  logic              push, pop, err_set;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign i_r   = ~full;
  assign o_v   = ~empty;
  assign cnt   = count;
  assign o_d   = mem[rptr];

  assign push = i_v & i_r;
  assign pop  = o_v & o_r;

  // stall_q remembers a valid that was offered but refused last cycle
  assign err_set = (o_r & ~o_v) | (stall_q & ~i_v);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wptr] <= i_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      stall_q <= i_v & ~i_r;
    end
  end

endmodule

// File: tb/tb_base_sfifo.sv
// Bench for base_sfifo (width=8, depth=4): directed table, hand sequences and
// random traffic checked against a queue model of the FIFO rules.
module tb_base_sfifo;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           reset, flush, i_v, o_r;
  logic [0:W-1]   i_d;
  logic           i_r, o_v, full, empty, err;
  logic [0:W-1]   o_d;
  logic [0:AW]    cnt;

  base_sfifo #(.width(W), .depth(DEPTH), .awidth(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d),
    .cnt(cnt), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit err_m, stall_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_ov",    {31'd0, o_v},   {31'd0, q.size() > 0});
    chk("m_ir",    {31'd0, i_r},   {31'd0, q.size() < DEPTH});
    chk("m_cnt",   {29'd0, cnt},   q.size());
    chk("m_full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
    chk("m_empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("m_err",   {31'd0, err},   {31'd0, err_m});
    if (q.size() > 0) chk("m_od", {24'd0, o_d}, {24'd0, q[0]});
  endtask

  // Apply one cycle of inputs, advance the reference model, compare after the edge
  task automatic cyc(input bit r, input bit f, input bit v, input logic [7:0] d, input bit rr);
    int sz;
    reset = r; flush = f; i_v = v; i_d = d; o_r = rr;
    sz = q.size();
    @(posedge clk);
    if (r) begin
      q.delete(); err_m = 0; stall_m = 0;
    end else begin
      if ((rr && sz == 0) || (stall_m && !v)) err_m = 1;
      stall_m = v && (sz == DEPTH);
      if (f) q.delete();
      else begin
        if (rr && sz > 0) void'(q.pop_front());
        if (v && sz < DEPTH) q.push_back(d);
      end
    end
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         rr;
    int         e_cnt;
    bit         e_ov;
    bit         e_ir;
    logic [7:0] e_od;
  } vec_t;

  vec_t tbl[11];
  bit r_b, f_b, v_b, rr_b;

  initial begin
    // fill to full, stall one word, then drain while the stalled word gets in
    tbl[0]  = '{1, 8'h11, 0, 1, 1, 1, 8'h11};
    tbl[1]  = '{1, 8'h22, 0, 2, 1, 1, 8'h11};
    tbl[2]  = '{1, 8'h33, 0, 3, 1, 1, 8'h11};
    tbl[3]  = '{1, 8'h44, 0, 4, 1, 0, 8'h11};
    tbl[4]  = '{1, 8'h55, 0, 4, 1, 0, 8'h11};
    tbl[5]  = '{1, 8'h55, 1, 3, 1, 1, 8'h22};
    tbl[6]  = '{1, 8'h55, 1, 3, 1, 1, 8'h33};
    tbl[7]  = '{0, 8'h00, 1, 2, 1, 1, 8'h44};
    tbl[8]  = '{0, 8'h00, 1, 1, 1, 1, 8'h55};
    tbl[9]  = '{0, 8'h00, 1, 0, 0, 1, 8'h00};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 8'h00};

    reset = 1; flush = 0; i_v = 0; i_d = '0; o_r = 0;
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    chk("rst_ov",    {31'd0, o_v},   32'd0);
    chk("rst_ir",    {31'd0, i_r},   32'd1);
    chk("rst_cnt",   {29'd0, cnt},   32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);

    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, tbl[i].v, tbl[i].d, tbl[i].rr);
      chk($sformatf("tbl%0d_cnt", i), {29'd0, cnt}, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ov", i), {31'd0, o_v}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_ir", i), {31'd0, i_r}, {31'd0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_full", i), {31'd0, full}, {31'd0, tbl[i].e_cnt == DEPTH});
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_od", i), {24'd0, o_d}, {24'd0, tbl[i].e_od});
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, 32'd0);
    end

    // steady push+pop at cnt=2 across several pointer wraps
    cyc(0, 0, 1, 8'h80, 0);
    cyc(0, 0, 1, 8'h81, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 8'h82 + 8'(i), 1);
      chk("pp_cnt", {29'd0, cnt}, 32'd2);
      chk("pp_od",  {24'd0, o_d}, {24'd0, 8'h81 + 8'(i)});
    end
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);

    // empty latency: nothing visible before the edge, data visible after
    i_v = 1; i_d = 8'hA5; o_r = 0;
    #1;
    chk("lat_pre_ov", {31'd0, o_v}, 32'd0);
    cyc(0, 0, 1, 8'hA5, 0);
    chk("lat_ov", {31'd0, o_v}, 32'd1);
    chk("lat_od", {24'd0, o_d}, 32'hA5);
    cyc(0, 0, 0, 8'h00, 1);

    // flush with a concurrent push drops everything
    cyc(0, 0, 1, 8'h01, 0);
    cyc(0, 0, 1, 8'h02, 0);
    cyc(0, 0, 1, 8'h03, 0);
    cyc(0, 1, 1, 8'hEE, 0);
    chk("fl_cnt", {29'd0, cnt}, 32'd0);
    chk("fl_ov",  {31'd0, o_v}, 32'd0);
    cyc(0, 0, 0, 8'h00, 0);
    chk("fl_lost", {29'd0, cnt}, 32'd0);

    // pop attempt on empty is sticky through flush
    cyc(0, 0, 0, 8'h00, 1);
    chk("e_pop_err", {31'd0, err}, 32'd1);
    cyc(0, 1, 0, 8'h00, 0);
    chk("e_flush_err", {31'd0, err}, 32'd1);

    // reset mid-burst with a concurrent push clears contents and err
    cyc(0, 0, 1, 8'h01, 0);
    cyc(0, 0, 1, 8'h02, 0);
    cyc(0, 0, 1, 8'h03, 0);
    cyc(1, 0, 1, 8'hEE, 0);
    chk("rs_cnt", {29'd0, cnt}, 32'd0);
    chk("rs_ov",  {31'd0, o_v}, 32'd0);
    chk("rs_err", {31'd0, err}, 32'd0);

    // withdraw valid while refused
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(i), 0);
    cyc(0, 0, 1, 8'h99, 0);
    chk("wd_hold_err", {31'd0, err}, 32'd0);
    cyc(0, 0, 0, 8'h00, 0);
    chk("wd_err", {31'd0, err}, 32'd1);
    cyc(1, 0, 0, 8'h00, 0);

    for (int i = 0; i < 600; i++) begin
      r_b  = ($urandom_range(0, 63) == 0);
      f_b  = ($urandom_range(0, 31) == 0);
      v_b  = stall_m ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 7);
      rr_b = (q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0);
      cyc(r_b, f_b, v_b, 8'($urandom), rr_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
